// File: rtl/aq_add_norm.sv
// aq_add_norm: normalizes an approximate adder's significand sum into binary16alt or binary8, via a 2-entry output FIFO.
// Optional round-to-nearest-even on the carry shift is enabled by defining APRX_NORM_RNE_EN.
`default_nettype none

module aq_add_norm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_fmt,
  input  logic [7:0]       in_exp,
  input  logic [8:0]       in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_c16,
  output logic [7:0]       out_c8,
  output logic             out_fmt,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int ENTRY_W = 26;

  logic [8:0] exp16;
  logic [6:0] frac16;
  logic       ovf16;
  logic [5:0] exp8;
  logic [1:0] frac8;
  logic       ovf8;

  always_comb begin
    exp16  = '0;
    frac16 = '0;
    ovf16  = 1'b0;
    if (in_exp == 8'hFF) begin
      exp16 = 9'h0FF;
    end else if (in_exp != 8'h00) begin
      if (in_sig[8]) begin
        exp16  = {1'b0, in_exp} + 9'd1;
        frac16 = in_sig[7:1];
`ifdef APRX_NORM_RNE_EN
        if (in_sig[0] && in_sig[1]) begin
          if (&in_sig[7:1]) begin
            frac16 = '0;
            exp16  = exp16 + 9'd1;
          end else begin
            frac16 = frac16 + 7'd1;
          end
        end
`endif
      end else if (in_sig[7]) begin
        exp16  = {1'b0, in_exp};
        frac16 = in_sig[6:0];
      end
      // Normalized exponent landing on all ones saturates to infinity.
      if (exp16 >= 9'd255) begin
        exp16  = 9'h0FF;
        frac16 = '0;
        ovf16  = 1'b1;
      end
    end
  end

  always_comb begin
    exp8  = '0;
    frac8 = '0;
    ovf8  = 1'b0;
    if (in_exp[4:0] == 5'h1F) begin
      exp8 = 6'h1F;
    end else if (in_exp[4:0] != 5'h00) begin
      if (in_sig[3]) begin
        exp8  = {1'b0, in_exp[4:0]} + 6'd1;
        frac8 = in_sig[2:1];
`ifdef APRX_NORM_RNE_EN
        if (in_sig[0] && in_sig[1]) begin
          if (&in_sig[2:1]) begin
            frac8 = '0;
            exp8  = exp8 + 6'd1;
          end else begin
            frac8 = frac8 + 2'd1;
          end
        end
`endif
      end else if (in_sig[2]) begin
        exp8  = {1'b0, in_exp[4:0]};
        frac8 = in_sig[1:0];
      end
      if (exp8 >= 6'd31) begin
        exp8  = 6'h1F;
        frac8 = '0;
        ovf8  = 1'b1;
      end
    end
  end

  logic [ENTRY_W-1:0] new_entry;
  assign new_entry = in_fmt ? {1'b1, ovf8, 16'h0000, 1'b0, exp8[4:0], frac8}
                            : {1'b0, ovf16, 1'b0, exp16[7:0], frac16, 8'h00};

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic               rdy_en;
  logic               push, pop, full;

  assign full      = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign in_ready  = rdy_en && (!full || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      rdy_en    <= 1'b0;
      ovf_count <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && out_ovf && !(&ovf_count)) ovf_count <= ovf_count + 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  logic [ENTRY_W-1:0] head;
  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign out_fmt = head[25];
  assign out_ovf = head[24];
  assign out_c16 = head[23:8];
  assign out_c8  = head[7:0];

endmodule

`default_nettype wire

// File: tb/tb_aq_add_norm.sv
// Directed-vector self-checking bench for aq_add_norm.
`default_nettype none

module tb_aq_add_norm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_fmt;
  logic [7:0]  in_exp;
  logic [8:0]  in_sig;
  logic        out_valid, out_ready;
  logic [15:0] out_c16;
  logic [7:0]  out_c8;
  logic        out_fmt, out_ovf;
  logic [15:0] ovf_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  aq_add_norm #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_exp(in_exp), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c16(out_c16), .out_c8(out_c8), .out_fmt(out_fmt), .out_ovf(out_ovf),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fmt;
    logic [7:0]  e;
    logic [8:0]  s;
    logic [15:0] c16;
    logic [7:0]  c8;
    logic        ovf;
  } vec_t;

  // {valid, fmt, ovf, c16, c8}
  function automatic logic [26:0] expect_of(vec_t v);
    return {1'b1, v.fmt, v.ovf, v.c16, v.c8};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = 1'b0; in_exp = '0; in_sig = '0; out_ready = 1'b0;
    #3;
    n_vec++;
    if ({out_valid, out_fmt, out_ovf, out_c16, out_c8, ovf_count} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b f=%b o=%b c16=%h c8=%h cnt=%0d want all zero",
               out_valid, out_fmt, out_ovf, out_c16, out_c8, ovf_count);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t vecs[13];
    vecs[0]  = '{1'b0, 8'h85, 9'h10D, 16'h4306, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h40, 9'h0AB, 16'h202B, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h40, 9'h05A, 16'h0000, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 9'h100, 16'h0000, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'hFF, 9'h100, 16'h7F80, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'hFE, 9'h180, 16'h7F80, 8'h00, 1'b1};
`ifdef APRX_NORM_RNE_EN
    vecs[6]  = '{1'b1, 8'h10, 9'h00F, 16'h0000, 8'h48, 1'b0};
    vecs[11] = '{1'b0, 8'h7F, 9'h1FF, 16'h4080, 8'h00, 1'b0};
`else
    vecs[6]  = '{1'b1, 8'h10, 9'h00F, 16'h0000, 8'h47, 1'b0};
    vecs[11] = '{1'b0, 8'h7F, 9'h1FF, 16'h407F, 8'h00, 1'b0};
`endif
    vecs[7]  = '{1'b1, 8'h05, 9'h006, 16'h0000, 8'h16, 1'b0};
    vecs[8]  = '{1'b1, 8'h1E, 9'h008, 16'h0000, 8'h7C, 1'b1};
    vecs[9]  = '{1'b1, 8'hE5, 9'h1F6, 16'h0000, 8'h16, 1'b0};
    vecs[10] = '{1'b0, 8'hFE, 9'h0FF, 16'h7F7F, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 8'h1F, 9'h008, 16'h0000, 8'h7C, 1'b0};
    for (int i = 0; i < 13; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_fmt = vecs[i].fmt; in_exp = vecs[i].e; in_sig = vecs[i].s;
      step();
      in_valid = 1'b0;
      n_vec++;
      if ({out_valid, out_fmt, out_ovf, out_c16, out_c8} !== expect_of(vecs[i])) begin
        n_err++;
        $display("FAIL vec%0d: got v=%b f=%b o=%b c16=%h c8=%h want %h", i,
                 out_valid, out_fmt, out_ovf, out_c16, out_c8, expect_of(vecs[i]));
      end
      n_vec++;
      if (ovf_count !== exp_cnt) begin
        n_err++;
        $display("FAIL vec%0d_cnt_before_pop: got %0d want %0d", i, ovf_count, exp_cnt);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (vecs[i].ovf) exp_cnt = exp_cnt + 16'd1;
      n_vec++;
      if ({out_valid, ovf_count} !== {1'b0, exp_cnt}) begin
        n_err++;
        $display("FAIL vec%0d_pop: got v=%b cnt=%0d want v=0 cnt=%0d", i, out_valid, ovf_count, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] a, b, c;
    a = {1'b1, 1'b0, 1'b0, 16'h4306, 8'h00};
    b = {1'b1, 1'b0, 1'b0, 16'h202B, 8'h00};
    c = {1'b1, 1'b1, 1'b0, 16'h0000, 8'h16};
    out_ready = 1'b0;
    in_valid = 1'b1; in_fmt = 1'b0; in_exp = 8'h85; in_sig = 9'h10D;
    step();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_1st: got %b want 1", in_ready); end
    in_exp = 8'h40; in_sig = 9'h0AB;
    step();
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_2nd: got %b want 0", in_ready); end
    in_fmt = 1'b1; in_exp = 8'h05; in_sig = 9'h006;
    step();
    n_vec++;
    if ({out_valid, out_fmt, out_ovf, out_c16, out_c8} !== a) begin
      n_err++; $display("FAIL b2b_hold_first: got c16=%h c8=%h v=%b want %h", out_c16, out_c8, out_valid, a);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_passthru: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_fmt, out_ovf, out_c16, out_c8} !== b) begin
      n_err++; $display("FAIL b2b_second: got c16=%h c8=%h want %h", out_c16, out_c8, b);
    end
    step();
    n_vec++;
    if ({out_valid, out_fmt, out_ovf, out_c16, out_c8} !== c) begin
      n_err++; $display("FAIL b2b_third: got f=%b c16=%h c8=%h want %h", out_fmt, out_c16, out_c8, c);
    end
    step();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_fmt = 1'b0; in_exp = 8'hFE; in_sig = 9'h180;
    step();
    in_exp = 8'h85; in_sig = 9'h10D;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_ovf, out_c16, ovf_count} !== 34'd0) begin
      n_err++;
      $display("FAIL flush_async: got v=%b o=%b c16=%h cnt=%0d want all zero", out_valid, out_ovf, out_c16, ovf_count);
    end
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({out_valid, in_ready, ovf_count} !== {1'b0, 1'b1, 16'd0}) begin
        n_err++;
        $display("FAIL flush_stale%0d: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", i, out_valid, in_ready, ovf_count);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
